// File: rtl/tmds_pll_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tmds_pll_pkg : FSM states and default rPLL pin codes for tmds_pll_ctrl   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package tmds_pll_pkg;

  localparam int SEL_W = 6;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_t;

  // Dynamic-select pin codes as presented to the rPLL, not divider values
  localparam logic [SEL_W-1:0] IDSEL_720P   = 6'd61;
  localparam logic [SEL_W-1:0] FBDSEL_720P  = 6'd3;
  localparam logic [SEL_W-1:0] ODSEL_720P   = 6'd62;
  localparam logic [SEL_W-1:0] IDSEL_1080P  = 6'd61;
  localparam logic [SEL_W-1:0] FBDSEL_1080P = 6'd3;
  localparam logic [SEL_W-1:0] ODSEL_1080P  = 6'd62;

endpackage
`default_nettype wire

// File: rtl/tmds_lock_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tmds_lock_sync : two-flop synchroniser for the rPLL LOCK pin, resets to 0 |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tmds_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tmds_pll_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tmds_pll_ctrl : rPLL mode select, reset sequencing and lock qualification |
// | Optional relock counter: define TMDS_PLL_RELOCK_CNT_EN.    Rev 1.0        |
// +--------------------------------------------------------------------------+
module tmds_pll_ctrl
  import tmds_pll_pkg::*;
#(
  parameter int NUM_MODES = 2,
  parameter logic [NUM_MODES*SEL_W-1:0] MODE_IDSEL  = {IDSEL_1080P, IDSEL_720P},
  parameter logic [NUM_MODES*SEL_W-1:0] MODE_FBDSEL = {FBDSEL_1080P, FBDSEL_720P},
  parameter logic [NUM_MODES*SEL_W-1:0] MODE_ODSEL  = {ODSEL_1080P, ODSEL_720P},
  parameter int RST_CYCLES   = 32,
  parameter int LOCK_STABLE  = 2700,
  parameter int LOCK_TIMEOUT = 270000,
  localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic [MW-1:0]    mode_sel,
  input  logic             mode_req,
  input  logic             pll_lock,
  output logic             pll_reset,
  output logic [SEL_W-1:0] idsel,
  output logic [SEL_W-1:0] fbdsel,
  output logic [SEL_W-1:0] odsel,
  output logic [MW-1:0]    mode_cur,
  output logic             busy,
  output logic             locked,
  output logic             tmds_rst,
  output logic             err,
  output logic             bad_req
`ifdef TMDS_PLL_RELOCK_CNT_EN
  ,output logic [7:0]      relock_cnt
`endif
);

  localparam int MAX_CNT =
    (RST_CYCLES > LOCK_STABLE)
      ? ((RST_CYCLES  > LOCK_TIMEOUT) ? RST_CYCLES  : LOCK_TIMEOUT)
      : ((LOCK_STABLE > LOCK_TIMEOUT) ? LOCK_STABLE : LOCK_TIMEOUT);
  localparam int CNT_W = $clog2(MAX_CNT) + 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [MW:0]      NUM_M       = (MW+1)'(NUM_MODES);

  pll_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lk;
  logic             req_ok, req_bad, timeout;

  logic [SEL_W-1:0] id_tab [NUM_MODES];
  logic [SEL_W-1:0] fb_tab [NUM_MODES];
  logic [SEL_W-1:0] od_tab [NUM_MODES];

  for (genvar g = 0; g < NUM_MODES; g++) begin : g_mode_tab
    assign id_tab[g] = MODE_IDSEL[g*SEL_W +: SEL_W];
    assign fb_tab[g] = MODE_FBDSEL[g*SEL_W +: SEL_W];
    assign od_tab[g] = MODE_ODSEL[g*SEL_W +: SEL_W];
  end

  tmds_lock_sync u_lock_sync (
    .clk (clkin),
    .rst (rst),
    .d   (pll_lock),
    .q   (lk)
  );

  assign req_ok    = mode_req && ({1'b0, mode_sel} <  NUM_M);
  assign req_bad   = mode_req && ({1'b0, mode_sel} >= NUM_M);
  assign pll_reset = (state == PLL_RST);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    timeout   = 1'b0;
    case (state)
      PLL_RST: begin
        if (cnt == RST_LAST) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (lk) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TO_LAST) begin
          timeout   = 1'b1;
          state_nxt = PLL_RST;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STABLE: begin
        if (!lk) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        if (!lk) begin
          state_nxt = PLL_RST;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = PLL_RST;
        cnt_nxt   = '0;
      end
    endcase
    // A valid request restarts the whole sequence from any state
    if (req_ok) begin
      state_nxt = PLL_RST;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state    <= PLL_RST;
      cnt      <= '0;
      mode_cur <= '0;
      idsel    <= MODE_IDSEL[SEL_W-1:0];
      fbdsel   <= MODE_FBDSEL[SEL_W-1:0];
      odsel    <= MODE_ODSEL[SEL_W-1:0];
      locked   <= 1'b0;
      tmds_rst <= 1'b1;
      busy     <= 1'b1;
      err      <= 1'b0;
      bad_req  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      locked   <= (state_nxt == RUN);
      tmds_rst <= (state_nxt != RUN);
      busy     <= (state_nxt != RUN);
      bad_req  <= req_bad;
      if (req_ok) begin
        err      <= 1'b0;
        mode_cur <= mode_sel;
        idsel    <= id_tab[mode_sel];
        fbdsel   <= fb_tab[mode_sel];
        odsel    <= od_tab[mode_sel];
      end else if (timeout) begin
        err <= 1'b1;
      end
    end
  end

`ifdef TMDS_PLL_RELOCK_CNT_EN
  // A request coinciding with a timeout pre-empts it, so only RUN losses count then
  logic relock_inc;
  assign relock_inc = ((state == RUN) && !lk) || (timeout && !req_ok);

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      relock_cnt <= '0;
    end else if (relock_inc && (relock_cnt != 8'hFF)) begin
      relock_cnt <= relock_cnt + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tmds_pll_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_tmds_pll_ctrl : randomized bench for tmds_pll_ctrl (2- and 3-mode)    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_tmds_pll_ctrl;

  localparam int RST_CYCLES   = 4;
  localparam int LOCK_STABLE  = 8;
  localparam int LOCK_TIMEOUT = 64;

  logic       clkin = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock = 1'b0;
  logic       mode_sel = 1'b0, mode_req = 1'b0;
  logic [1:0] mode_sel_b = 2'd0;
  logic       mode_req_b = 1'b0;

  logic       pll_reset, busy, locked, tmds_rst, err, bad_req;
  logic [5:0] idsel, fbdsel, odsel;
  logic       mode_cur;
  logic       pll_reset_b, busy_b, locked_b, tmds_rst_b, err_b, bad_req_b;
  logic [5:0] idsel_b, fbdsel_b, odsel_b;
  logic [1:0] mode_cur_b;
`ifdef TMDS_PLL_RELOCK_CNT_EN
  logic [7:0] relock_cnt, relock_cnt_b;
`endif

  always #5 clkin = ~clkin;

  tmds_pll_ctrl #(
    .NUM_MODES(2), .MODE_IDSEL({6'd61, 6'd61}), .MODE_FBDSEL({6'd10, 6'd3}),
    .MODE_ODSEL({6'd62, 6'd62}), .RST_CYCLES(RST_CYCLES),
    .LOCK_STABLE(LOCK_STABLE), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clkin(clkin), .rst(rst), .mode_sel(mode_sel), .mode_req(mode_req),
    .pll_lock(pll_lock), .pll_reset(pll_reset), .idsel(idsel), .fbdsel(fbdsel),
    .odsel(odsel), .mode_cur(mode_cur), .busy(busy), .locked(locked),
    .tmds_rst(tmds_rst), .err(err), .bad_req(bad_req)
`ifdef TMDS_PLL_RELOCK_CNT_EN
    , .relock_cnt(relock_cnt)
`endif
  );

  tmds_pll_ctrl #(
    .NUM_MODES(3), .MODE_IDSEL({6'd50, 6'd40, 6'd61}),
    .MODE_FBDSEL({6'd20, 6'd10, 6'd3}), .MODE_ODSEL({6'd60, 6'd61, 6'd62}),
    .RST_CYCLES(RST_CYCLES), .LOCK_STABLE(LOCK_STABLE), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut_b (
    .clkin(clkin), .rst(rst), .mode_sel(mode_sel_b), .mode_req(mode_req_b),
    .pll_lock(pll_lock), .pll_reset(pll_reset_b), .idsel(idsel_b), .fbdsel(fbdsel_b),
    .odsel(odsel_b), .mode_cur(mode_cur_b), .busy(busy_b), .locked(locked_b),
    .tmds_rst(tmds_rst_b), .err(err_b), .bad_req(bad_req_b)
`ifdef TMDS_PLL_RELOCK_CNT_EN
    , .relock_cnt(relock_cnt_b)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: phase is tracked as "reset cycles left", "lock-high cycles
  // seen in a row", "cycles waited without lock" and a running flag.
  int nmodes [2] = '{2, 3};
  int tab_id [2][3] = '{'{61, 61, 0}, '{61, 40, 50}};
  int tab_fb [2][3] = '{'{3, 10, 0}, '{3, 10, 20}};
  int tab_od [2][3] = '{'{62, 62, 0}, '{62, 61, 60}};
  int m_mode [2], m_err [2], m_relock [2], m_bad [2];
  int m_rst_left [2], m_good [2], m_wait [2], m_run [2];
  bit lk_h0, lk_h1;

  task automatic restart(input int u);
    m_rst_left[u] = RST_CYCLES;
    m_run[u] = 0; m_good[u] = 0; m_wait[u] = 0;
  endtask

  task automatic bump(input int u);
    if (m_relock[u] < 255) m_relock[u]++;
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_mode[u] = 0; m_err[u] = 0; m_relock[u] = 0; m_bad[u] = 0;
      restart(u);
    end
    lk_h0 = 0; lk_h1 = 0;
  endtask

  task automatic model_step(input int u, input bit req, input int sel, input bit lk);
    m_bad[u] = (req && sel >= nmodes[u]) ? 1 : 0;
    if (req && sel < nmodes[u]) begin
      if (m_run[u] != 0 && !lk) bump(u);
      m_mode[u] = sel; m_err[u] = 0;
      restart(u);
    end else if (m_rst_left[u] > 0) begin
      m_rst_left[u]--;
    end else if (m_run[u] != 0) begin
      if (!lk) begin bump(u); restart(u); end
    end else if (m_good[u] > 0) begin
      if (!lk) begin
        m_good[u] = 0; m_wait[u] = 0;
      end else begin
        m_good[u]++;
        if (m_good[u] == LOCK_STABLE + 1) m_run[u] = 1;
      end
    end else if (lk) begin
      m_good[u] = 1;
    end else begin
      m_wait[u]++;
      if (m_wait[u] == LOCK_TIMEOUT) begin
        m_err[u] = 1; bump(u); restart(u);
      end
    end
  endtask

  task automatic compare_all();
    check_eq("pll_reset", pll_reset, m_rst_left[0] > 0);
    check_eq("idsel", idsel, tab_id[0][m_mode[0]]);
    check_eq("fbdsel", fbdsel, tab_fb[0][m_mode[0]]);
    check_eq("odsel", odsel, tab_od[0][m_mode[0]]);
    check_eq("mode_cur", mode_cur, m_mode[0]);
    check_eq("busy", busy, m_run[0] == 0);
    check_eq("locked", locked, m_run[0]);
    check_eq("tmds_rst", tmds_rst, m_run[0] == 0);
    check_eq("err", err, m_err[0]);
    check_eq("bad_req", bad_req, m_bad[0]);
    check_eq("b_pll_reset", pll_reset_b, m_rst_left[1] > 0);
    check_eq("b_idsel", idsel_b, tab_id[1][m_mode[1]]);
    check_eq("b_fbdsel", fbdsel_b, tab_fb[1][m_mode[1]]);
    check_eq("b_odsel", odsel_b, tab_od[1][m_mode[1]]);
    check_eq("b_mode_cur", mode_cur_b, m_mode[1]);
    check_eq("b_locked", locked_b, m_run[1]);
    check_eq("b_busy", busy_b, m_run[1] == 0);
    check_eq("b_err", err_b, m_err[1]);
    check_eq("b_bad_req", bad_req_b, m_bad[1]);
`ifdef TMDS_PLL_RELOCK_CNT_EN
    check_eq("relock_cnt", relock_cnt, m_relock[0]);
    check_eq("b_relock_cnt", relock_cnt_b, m_relock[1]);
`endif
  endtask

  // Called just after a falling edge: drive, advance the model, then compare
  task automatic cycle(input bit lock, input bit r0, input int s0, input bit r1, input int s1);
    bit lk;
    pll_lock = lock; mode_req = r0; mode_sel = s0[0];
    mode_req_b = r1; mode_sel_b = s1[1:0];
    lk = lk_h1; lk_h1 = lk_h0; lk_h0 = lock;
    model_step(0, r0, s0, lk);
    model_step(1, r1, s1, lk);
    @(posedge clkin);
    @(negedge clkin);
    mode_req = 1'b0; mode_req_b = 1'b0;
    compare_all();
  endtask

  task automatic idle(input bit lock);
    cycle(lock, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    compare_all();
    check_eq("arst_pll_reset", pll_reset, 1);
    check_eq("arst_fbdsel", fbdsel, 3);
    @(posedge clkin);
    @(negedge clkin);
    rst = 1'b0;
    compare_all();
  endtask

  initial begin
    int n, n_pr, n_w, kind, len;
    bit done, lv, r0, r1;
    int s0, s1;

    model_reset();
    repeat (3) @(negedge clkin);
    compare_all();
    check_eq("rst_locked", locked, 0);
    check_eq("rst_tmds_rst", tmds_rst, 1);
    check_eq("rst_busy", busy, 1);

    // Power-up
    rst = 1'b0;
    n = pll_reset ? 1 : 0;
    for (int i = 0; i < 10; i++) begin idle(1'b0); if (pll_reset) n++; end
    check_eq("pwrup_rst_width", n, RST_CYCLES);
    n = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin idle(1'b1); n++; if (locked) done = 1; end
    check_eq("pwrup_lock_lat", n, 2 + LOCK_STABLE + 1);
    check_eq("pwrup_fbdsel", fbdsel, 3);

    // Mode switch to mode 1
    cycle(1'b1, 1'b1, 1, 1'b0, 0);
    check_eq("sw_tmds_rst", tmds_rst, 1);
    check_eq("sw_fbdsel", fbdsel, 10);
    check_eq("sw_mode_cur", mode_cur, 1);
    n = pll_reset ? 1 : 0;
    for (int i = 0; i < 10; i++) begin idle(1'b1); if (pll_reset) n++; end
    check_eq("sw_rst_width", n, RST_CYCLES);
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin idle(1'b1); if (locked) done = 1; end
    check_eq("sw_relock", locked, 1);

    // One-cycle lock glitch during STABLE
    cycle(1'b1, 1'b1, 1, 1'b0, 0);
    repeat (3) idle(1'b1);
    idle(1'b0);
    n = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin idle(1'b1); n++; if (locked) done = 1; end
    check_eq("glitch_lat", n, 2 + LOCK_STABLE + 1);

    // Lock loss in RUN, then timeout
    n = 0; done = 0;
    for (int i = 0; i < 10 && !done; i++) begin idle(1'b0); n++; if (tmds_rst) done = 1; end
    check_eq("loss_lat", n, 3);
    n_pr = pll_reset ? 1 : 0; n_w = 0; done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      idle(1'b0);
      if (err) done = 1;
      else if (pll_reset) n_pr++;
      else n_w++;
    end
    check_eq("loss_rst_width", n_pr, RST_CYCLES);
    check_eq("to_wait_cycles", n_w, LOCK_TIMEOUT);
    check_eq("to_err", err, 1);
`ifdef TMDS_PLL_RELOCK_CNT_EN
    check_eq("to_relock_cnt", relock_cnt, 2);
`endif
    repeat (2) idle(1'b0);
    check_eq("to_retry_rst", pll_reset, 1);
    cycle(1'b0, 1'b1, 0, 1'b0, 0);
    check_eq("req_clears_err", err, 0);

    // Rejected request on the 3-mode instance, then a valid one
    cycle(1'b0, 1'b0, 0, 1'b1, 3);
    check_eq("bad_req_pulse", bad_req_b, 1);
    check_eq("bad_req_mode", mode_cur_b, 0);
    idle(1'b0);
    check_eq("bad_req_end", bad_req_b, 0);
    cycle(1'b0, 1'b0, 0, 1'b1, 2);
    check_eq("b_mode2_fbdsel", fbdsel_b, 20);

    // Randomized episodes
    for (int ep = 0; ep < 140; ep++) begin
      kind = $urandom_range(0, 9);
      if (kind == 9 && $urandom_range(0, 3) != 0) kind = 0;
      case (kind)
        6:       begin lv = 1'b0; len = $urandom_range(1, 3); end
        7, 8:    begin lv = 1'b0; len = $urandom_range(20, 150); end
        9:       begin lv = pll_lock; len = 0; async_reset(); end
        default: begin lv = 1'b1; len = $urandom_range(5, 40); end
      endcase
      for (int i = 0; i < len; i++) begin
        r0 = ($urandom_range(0, 59) == 0);
        s0 = $urandom_range(0, 1);
        r1 = ($urandom_range(0, 39) == 0);
        s1 = $urandom_range(0, 3);
        cycle(lv, r0, s0, r1, s1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
